uncached_store_queue: RTL
=========================

# uncached_store_queue

Buffers uncached stores from the dcache and drains them one at a time as single-beat AXI writes through the write buffer's uncached pass-through port (`dch_*` / `uchd_wreq`). It sits directly upstream of the write buffer. It decouples the pipeline from AXI write latency and preserves program order among uncached stores. It also reports pending same-word stores so uncached loads can wait for them.

## Interface
Parameters:
- `DEPTH`, 4: number of store entries; must be a power of two, ≥2.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `st_valid` in 1: dcache presents an uncached store.
- `st_ready` out 1: entry accepted this cycle when `st_valid & st_ready`.
- `st_addr` in 32: store byte address.
- `st_data` in 32: store data, byte lanes already aligned.
- `st_strb` in 4: byte enables.
- `ld_addr` in 32: address of a pending uncached load.
- `ld_conflict` out 1: combinational; a queued or in-flight entry matches `ld_addr[31:2]`.
- `empty` out 1: no entries and FSM in IDLE.
- `wb_busy` in 1: write buffer is not idle (clearing or lookup); a new drain must not start.
- `uchd_wreq` out 1: claims the write buffer's AXI write path.
- `dch_awaddr` out 32: write address.
- `dch_awlen` out 4: write burst length.
- `dch_awburst` out 2: write burst type.
- `dch_awvalid` out 1: address valid.
- `dch_awready` in 1: address accepted.
- `dch_wdata` out 32: write data.
- `dch_wstrb` out 4: write byte enables.
- `dch_wlast` out 1: last data beat.
- `dch_wvalid` out 1: data valid.
- `dch_wready` in 1: data accepted.
- `dch_bvalid` in 1: write response (the write buffer holds `bready` at 1; no `bready` here).

## Operation
- FIFO: head/tail pointers of width log2(DEPTH) wrap modulo DEPTH. `count` is a (log2(DEPTH)+1)-bit register.
- `st_ready = (count != DEPTH)`, computed from the registered count. A push is refused when full, even if a pop happens in the same cycle.
- On push: write the entry at tail, then tail++.
- On pop: head++. Push and pop in the same cycle leave `count` unchanged.
- FSM states:
  - IDLE: if `count != 0 && !wb_busy`, go to AW. `wb_busy` is sampled only in IDLE.
  - AW: `uchd_wreq=1`, `dch_awvalid=1`, `dch_awaddr=head.addr`. On `dch_awready`, go to W.
  - W: `uchd_wreq=1`, `dch_wvalid=1`, `dch_wlast=1`, `dch_wdata=head.data`, `dch_wstrb=head.strb`. On `dch_wready`, go to B.
  - B: `uchd_wreq=1`. On `dch_bvalid`, pop head and go to IDLE.
- `dch_awlen=0` and `dch_awburst=2'b01` are constant. AW/W outputs are 0 outside their own state.
- The head entry stays valid, and stays visible to `ld_conflict`, until its B response arrives.
- `ld_conflict` compares `ld_addr[31:2]` against every occupied slot, head through tail-1, wrap included. A store presented on `st_valid` in the same cycle is not compared.
- No write merging; each store is one AXI transaction.

## Timing
- Reset values:
  - FIFO: count=0, head=tail=0.
  - FSM: IDLE.
  - Outputs: `st_ready=1`, `empty=1`, `ld_conflict=0`, `uchd_wreq=0`, all valids 0.
- Drain start: a push in cycle t makes count=1 in t+1; IDLE moves to AW, so `dch_awvalid` rises at t+2.
- Minimum per-store occupancy is 4 cycles (IDLE, AW, W, B) with zero-wait slave responses.
- `uchd_wreq` is held continuously from entry to AW through the `dch_bvalid` cycle, inclusive. It drops in the following IDLE cycle.
- If `wb_busy` is set in IDLE, stay in IDLE indefinitely. `wb_busy` asserting after AW has been entered is ignored.
- Reset mid-transaction: everything returns to reset values in the next cycle, and the outstanding AXI transaction is abandoned (system-wide reset).
- `empty` falls in the cycle after a push. It rises in the cycle after the last `dch_bvalid`.

## Structure
- `dcache_pkg` holds:
  - the uncached entry struct {addr[31:0], data[31:0], strb[3:0]};
  - the FSM state enum;
  - AXI constants `AXI_BURST_INCR=2'b01` and `AXI_LEN_SINGLE=4'd0`.
- One sub-module, `uc_store_fifo`, holds the entry storage, pointers, count, full/empty flags and the conflict comparator array. The FSM and AXI drive logic stay in the top.

## Test plan
- Single store: push 0xBFD0_F000 / 0x1234_5678 / strb 0xF; slave has zero wait. Expect `dch_awvalid` at t+2, W at t+3, `uchd_wreq` high t+2 to t+4, and `empty` back at t+5.
- Fill: push 5 stores back to back with `dch_awready=0`. Expect the 5th refused (`st_ready=0` at count=4). Release the slave; expect 4 writes issued in push order.
- Wrap: 10 pushes and pops interleaved with random AW/W/B stalls. Expect the AXI order to match the push order exactly, with pointers wrapping past DEPTH-1.
- Conflict: queue stores to 0x1FC0_0004 and 0x1FC0_0010. `ld_addr=0x1FC0_0006` gives `ld_conflict=1`; `0x1FC0_0008` gives 0. After the first B response, `0x1FC0_0006` gives 0.
- `wb_busy` gating: hold `wb_busy=1` for 20 cycles with count=2. Expect no `uchd_wreq`; the drain starts the cycle after `wb_busy` falls.
- Reset mid-W: assert `rst` while in W. Expect all outputs at reset values next cycle and `count=0`.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and constants for the dcache uncached store path.
// Contents:
//   uc_entry_t      one queued uncached store {addr, data, strb}
//   uc_state_t      drain FSM states of uncached_store_queue
//   AXI_BURST_INCR  burst type driven on every uncached write
//   AXI_LEN_SINGLE  burst length for a single-beat write
package dcache_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } uc_entry_t;

    typedef enum logic [1:0] {
        UC_IDLE = 2'd0,
        UC_AW   = 2'd1,
        UC_W    = 2'd2,
        UC_B    = 2'd3
    } uc_state_t;

endpackage

// File: rtl/uc_store_fifo.sv
// Entry storage for the uncached store queue: circular buffer with head/tail
// pointers, occupancy count, full/empty flags and a per-slot word-address
// comparator used to flag loads that must wait for a pending store.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   push         write wr_entry at tail (ignored when full)
//   pop          retire the head entry
//   wr_entry     entry to enqueue
//   head_entry   oldest entry (valid while not empty)
//   ld_word      load word address (byte address bits [31:2])
//   ld_conflict  some occupied slot holds the same word address
//   full, empty  occupancy flags from the registered count
module uc_store_fifo
    import dcache_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  uc_entry_t   wr_entry,
    output uc_entry_t   head_entry,
    input  logic [29:0] ld_word,
    output logic        ld_conflict,
    output logic        full,
    output logic        empty
);

    localparam int PTR_W = $clog2(DEPTH);

    uc_entry_t            mem [DEPTH];
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [PTR_W:0]       count;
    logic                 push_ok;
    logic [DEPTH-1:0]     occupied;

    assign full       = (count == (PTR_W+1)'(DEPTH));
    assign empty      = (count == '0);
    // A full queue refuses the push even if the head retires this cycle.
    assign push_ok    = push && !full;
    assign head_entry = mem[head];

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_ok) tail <= tail + 1'b1;
            if (pop)     head <= head + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[tail] <= wr_entry;
    end

    // Slot i is occupied when its distance from head (mod DEPTH) is below
    // count; this covers the wrapped case without separate logic.
    always_comb begin
        occupied    = '0;
        ld_conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            occupied[i] = ({1'b0, PTR_W'(i) - head} < count);
            if (occupied[i] && (mem[i].addr[31:2] == ld_word))
                ld_conflict = 1'b1;
        end
    end

endmodule

// File: rtl/uncached_store_queue.sv
// Uncached store queue: buffers uncached stores from the dcache and drains
// them in program order as single-beat AXI writes through the write buffer's
// uncached pass-through port. Flags loads whose word matches a pending store.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   st_valid/st_ready/st_addr/st_data/st_strb   store push handshake
//   ld_addr, ld_conflict          pending-load address, same-word hit
//   empty                         nothing queued and drain FSM idle
//   wb_busy                       write buffer busy; blocks a new drain
//   uchd_wreq                     claims the write buffer AXI write path
//   dch_aw*/dch_w*/dch_bvalid     single-beat AXI write channel
//
// state   | meaning
// --------+-----------------------------------------------------------
// UC_IDLE | no write outstanding; start when an entry waits and !wb_busy
// UC_AW   | address phase for the head entry
// UC_W    | single data beat for the head entry
// UC_B    | waiting for the write response; head retires on bvalid
module uncached_store_queue
    import dcache_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [3:0]  st_strb,
    input  logic [31:0] ld_addr,
    output logic        ld_conflict,
    output logic        empty,
    input  logic        wb_busy,
    output logic        uchd_wreq,
    output logic [31:0] dch_awaddr,
    output logic [3:0]  dch_awlen,
    output logic [1:0]  dch_awburst,
    output logic        dch_awvalid,
    input  logic        dch_awready,
    output logic [31:0] dch_wdata,
    output logic [3:0]  dch_wstrb,
    output logic        dch_wlast,
    output logic        dch_wvalid,
    input  logic        dch_wready,
    input  logic        dch_bvalid
);

    uc_state_t state;
    uc_entry_t wr_entry;
    uc_entry_t head_entry;
    logic      fifo_full;
    logic      fifo_empty;
    logic      push;
    logic      pop;
    logic      unused_ld_bits;

    // The byte offset inside the word does not matter for the hazard check.
    assign unused_ld_bits = ^ld_addr[1:0];

    assign wr_entry    = '{addr: st_addr, data: st_data, strb: st_strb};
    assign st_ready    = !fifo_full;
    assign push        = st_valid && st_ready;
    // The head stays queued (and visible to ld_conflict) until its response.
    assign pop         = (state == UC_B) && dch_bvalid;
    assign empty       = fifo_empty && (state == UC_IDLE);
    assign dch_awlen   = AXI_LEN_SINGLE;
    assign dch_awburst = AXI_BURST_INCR;

    uc_store_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .pop         (pop),
        .wr_entry    (wr_entry),
        .head_entry  (head_entry),
        .ld_word     (ld_addr[31:2]),
        .ld_conflict (ld_conflict),
        .full        (fifo_full),
        .empty       (fifo_empty)
    );

    // Outputs are registered alongside the state so each one takes its value
    // for the state being entered; the head entry cannot change mid-write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= UC_IDLE;
            uchd_wreq   <= 1'b0;
            dch_awvalid <= 1'b0;
            dch_awaddr  <= '0;
            dch_wvalid  <= 1'b0;
            dch_wlast   <= 1'b0;
            dch_wdata   <= '0;
            dch_wstrb   <= '0;
        end else begin
            case (state)
                UC_IDLE: begin
                    if (!fifo_empty && !wb_busy) begin
                        state       <= UC_AW;
                        uchd_wreq   <= 1'b1;
                        dch_awvalid <= 1'b1;
                        dch_awaddr  <= head_entry.addr;
                    end
                end
                UC_AW: begin
                    if (dch_awready) begin
                        state       <= UC_W;
                        dch_awvalid <= 1'b0;
                        dch_awaddr  <= '0;
                        dch_wvalid  <= 1'b1;
                        dch_wlast   <= 1'b1;
                        dch_wdata   <= head_entry.data;
                        dch_wstrb   <= head_entry.strb;
                    end
                end
                UC_W: begin
                    if (dch_wready) begin
                        state      <= UC_B;
                        dch_wvalid <= 1'b0;
                        dch_wlast  <= 1'b0;
                        dch_wdata  <= '0;
                        dch_wstrb  <= '0;
                    end
                end
                UC_B: begin
                    if (dch_bvalid) begin
                        state     <= UC_IDLE;
                        uchd_wreq <= 1'b0;
                    end
                end
                default: begin
                    state       <= UC_IDLE;
                    uchd_wreq   <= 1'b0;
                    dch_awvalid <= 1'b0;
                    dch_wvalid  <= 1'b0;
                    dch_wlast   <= 1'b0;
                end
            endcase
        end
    end

endmodule
